alu_cmd_sched: RTL
==================

# alu_cmd_sched

Command scheduler between the UART receiver/transmitter and the ALU. It collects a 3-byte command frame (opcode, A, B) from the RX byte stream, validates the opcode and issues one ALU operation. It then captures the 2·DATA_WIDTH result and flags and streams a 3-byte response (result low, result high, flags) to the TX. It is the only master of the ALU in the UART system top.

## Interface
- DATA_WIDTH, 8, byte width; equals the UART frame width.
- ALU_FUN_WIDTH, 4, opcode field width.
- NUM_OPS, 14, number of legal opcodes; legal codes are 0..NUM_OPS-1.
- GAP_TIMEOUT, 1024, maximum idle cycles allowed between bytes of one frame.
- ALU_WAIT, 4, maximum cycles to wait for ALU valid after issue.
- ERR_BYTE, 8'hEE, response byte for a rejected command.
- i_CLK  in  1  clock; the single clock of the block.
- i_RST  in  1  reset; synchronous, active-high.
- i_RX_DATA  in  DATA_WIDTH  received byte.
- i_RX_VALID  in  1  one-cycle strobe; i_RX_DATA is valid this cycle.
- o_ALU_FUN  out  ALU_FUN_WIDTH  registered opcode.
- o_ALU_A, o_ALU_B  out  DATA_WIDTH  registered operands.
- o_ALU_EN  out  1  one-cycle issue pulse.
- i_ALU_OUT  in  2*DATA_WIDTH  ALU result.
- i_ALU_CF, i_ALU_OF, i_ALU_EF, i_ALU_ZF  in  1  ALU flags.
- i_ALU_VALID  in  1  ALU output valid.
- o_TX_DATA  out  DATA_WIDTH  byte to transmit.
- o_TX_VALID  out  1  o_TX_DATA is presented.
- i_TX_READY  in  1  TX accepts a byte when o_TX_VALID and i_TX_READY are both high on a rising edge.
- o_BUSY  out  1  high in any state other than IDLE, GET_A or GET_B.
- o_OVERRUN  out  1  sticky; an RX byte arrived while o_BUSY was high. Cleared only by i_RST.
- o_FRAME_ERR  out  1  one-cycle pulse on a gap timeout.

## Operation
- States: IDLE, GET_A, GET_B, EXEC, WAIT_RES, SEND_LO, SEND_HI, SEND_FLG, SEND_ERR.
- IDLE, on i_RX_VALID: latch opcode from i_RX_DATA[ALU_FUN_WIDTH-1:0]. Set an illegal flag if the opcode ≥ NUM_OPS or i_RX_DATA[DATA_WIDTH-1:ALU_FUN_WIDTH] ≠ 0. Go to GET_A.
- GET_A, on i_RX_VALID: latch A, go to GET_B.
- GET_B, on i_RX_VALID: latch B. If illegal, go to SEND_ERR; otherwise go to EXEC. An illegal frame is still fully consumed so the stream stays aligned.
- Gap timer: reset on every accepted byte. In GET_A or GET_B, reaching GAP_TIMEOUT cycles without a byte → pulse o_FRAME_ERR, discard the partial frame, go to IDLE. No response byte is sent.
- EXEC: o_ALU_EN=1 for exactly one cycle, with o_ALU_FUN/A/B stable. Go to WAIT_RES.
- WAIT_RES:
  - i_ALU_VALID high → capture i_ALU_OUT into the result register and {4'b0, CF, OF, EF, ZF} into the flags byte. Go to SEND_LO.
  - ALU_WAIT cycles with no valid → go to SEND_ERR.
- SEND_LO → SEND_HI → SEND_FLG: present result[7:0], then result[15:8], then the flags byte. Each state holds o_TX_VALID=1 with stable data until accepted, then advances. After SEND_FLG is accepted, go to IDLE.
- SEND_ERR: present ERR_BYTE; on acceptance go to IDLE.
- i_RX_VALID while o_BUSY: the byte is dropped and o_OVERRUN is set. A byte arriving in the same cycle as the final TX acceptance is also dropped, because o_BUSY is still high in that cycle.
- o_ALU_FUN/A/B hold their values outside EXEC; they change only when a byte is latched.

## Timing
- Reset (i_RST high at a rising edge) forces, regardless of the current state:
  - state IDLE; timers cleared;
  - o_ALU_EN, o_TX_VALID, o_BUSY, o_OVERRUN, o_FRAME_ERR = 0;
  - o_ALU_FUN, o_ALU_A, o_ALU_B, o_TX_DATA = 0.
  A transfer in progress is abandoned without completing.
- B byte accepted at edge t: o_ALU_EN high in cycle t+1. i_ALU_VALID is sampled in cycles t+2 through t+1+ALU_WAIT.
- With a 1-cycle ALU, the first o_TX_VALID is in cycle t+3.
- With i_TX_READY held high, the three response bytes take three consecutive cycles, and o_BUSY falls in the cycle after the third is accepted.
- The gap timer counts cycles with no i_RX_VALID. A byte arriving in the cycle the count reaches GAP_TIMEOUT is rejected, and the timeout wins.

## Test plan
- ADD frame 0x00, 0x25, 0x17, i_TX_READY=1 → o_ALU_EN one cycle after B; TX bytes 0x3C, 0x00, 0x00; o_BUSY low afterwards.
- MUL frame 0x02, 0xFF, 0xFF with i_TX_READY stalled 5 cycles per byte → TX bytes 0x01, 0xFE, then the flags byte. o_TX_DATA is stable during every stall.
- Illegal opcode 0x0F, 0x11, 0x22 → no o_ALU_EN; single TX byte 0xEE.
- Opcode 0x00, A=0x10, then silence for GAP_TIMEOUT cycles → o_FRAME_ERR pulse, no TX. A following valid frame 0x05, 0x0F, 0xF0 → normal response.
- ALU model that never asserts valid → 0xEE sent ALU_WAIT+1 cycles after issue. An RX byte injected during that wait sets o_OVERRUN.
- i_RST asserted during SEND_HI → next cycle o_TX_VALID=0, o_BUSY=0, o_OVERRUN=0; the next frame completes normally.

Source files
------------

// File: rtl/alu_cmd_sched.sv
// Collects opcode/A/B frames from RX, issues one ALU op, streams result lo/hi/flags (or ERR_BYTE) to TX.
// ALU_EN one cycle after B; first TX byte two cycles later with a 1-cycle ALU; TX bytes hold until i_TX_READY.
module alu_cmd_sched #(
  parameter int                  DATA_WIDTH    = 8,
  parameter int                  ALU_FUN_WIDTH = 4,
  parameter int                  NUM_OPS       = 14,
  parameter int                  GAP_TIMEOUT   = 1024,
  parameter int                  ALU_WAIT      = 4,
  parameter logic [DATA_WIDTH-1:0] ERR_BYTE    = 8'hEE
) (
  input  logic                       i_CLK,
  input  logic                       i_RST,
  input  logic [DATA_WIDTH-1:0]      i_RX_DATA,
  input  logic                       i_RX_VALID,
  output logic [ALU_FUN_WIDTH-1:0]   o_ALU_FUN,
  output logic [DATA_WIDTH-1:0]      o_ALU_A,
  output logic [DATA_WIDTH-1:0]      o_ALU_B,
  output logic                       o_ALU_EN,
  input  logic [2*DATA_WIDTH-1:0]    i_ALU_OUT,
  input  logic                       i_ALU_CF,
  input  logic                       i_ALU_OF,
  input  logic                       i_ALU_EF,
  input  logic                       i_ALU_ZF,
  input  logic                       i_ALU_VALID,
  output logic [DATA_WIDTH-1:0]      o_TX_DATA,
  output logic                       o_TX_VALID,
  input  logic                       i_TX_READY,
  output logic                       o_BUSY,
  output logic                       o_OVERRUN,
  output logic                       o_FRAME_ERR
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GET_A    = 4'd1;
  localparam logic [3:0] S_GET_B    = 4'd2;
  localparam logic [3:0] S_EXEC     = 4'd3;
  localparam logic [3:0] S_WAIT_RES = 4'd4;
  localparam logic [3:0] S_SEND_LO  = 4'd5;
  localparam logic [3:0] S_SEND_HI  = 4'd6;
  localparam logic [3:0] S_SEND_FLG = 4'd7;
  localparam logic [3:0] S_SEND_ERR = 4'd8;

  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam int WW = $clog2(ALU_WAIT + 1);
  localparam logic [GW-1:0]            GAP_MAX   = GW'(GAP_TIMEOUT);
  localparam logic [WW-1:0]            WAIT_LAST = WW'(ALU_WAIT - 1);
  localparam logic [ALU_FUN_WIDTH:0]   OPS_LIM   = (ALU_FUN_WIDTH + 1)'(NUM_OPS);

  logic [3:0]                 r_state;
  logic [GW-1:0]              r_gap;
  logic [WW-1:0]              r_wait;
  logic                       r_illegal;
  logic [ALU_FUN_WIDTH-1:0]   r_fun;
  logic [DATA_WIDTH-1:0]      r_a;
  logic [DATA_WIDTH-1:0]      r_b;
  logic [2*DATA_WIDTH-1:0]    r_res;
  logic [DATA_WIDTH-1:0]      r_flg;
  logic                       r_overrun;

  logic w_busy;
  logic w_gap_to;
  logic w_op_bad;

  assign w_busy   = !(r_state == S_IDLE || r_state == S_GET_A || r_state == S_GET_B);
  // Timeout has priority over a byte landing in the same cycle.
  assign w_gap_to = (r_state == S_GET_A || r_state == S_GET_B) && (r_gap == GAP_MAX);
  assign w_op_bad = ({1'b0, i_RX_DATA[ALU_FUN_WIDTH-1:0]} >= OPS_LIM) ||
                    (|i_RX_DATA[DATA_WIDTH-1:ALU_FUN_WIDTH]);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state   <= S_IDLE;
      r_gap     <= '0;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_fun     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_flg     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (i_RX_VALID && w_busy) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (i_RX_VALID) begin
          r_fun     <= i_RX_DATA[ALU_FUN_WIDTH-1:0];
          r_illegal <= w_op_bad;
          r_gap     <= '0;
          r_state   <= S_GET_A;
        end
        S_GET_A: begin
          if (w_gap_to) begin
            r_gap   <= '0;
            r_state <= S_IDLE;
          end else if (i_RX_VALID) begin
            r_a     <= i_RX_DATA;
            r_gap   <= '0;
            r_state <= S_GET_B;
          end else r_gap <= r_gap + GW'(1);
        end
        S_GET_B: begin
          if (w_gap_to) begin
            r_gap   <= '0;
            r_state <= S_IDLE;
          end else if (i_RX_VALID) begin
            r_b     <= i_RX_DATA;
            r_gap   <= '0;
            r_state <= r_illegal ? S_SEND_ERR : S_EXEC;
          end else r_gap <= r_gap + GW'(1);
        end
        S_EXEC: begin
          r_wait  <= '0;
          r_state <= S_WAIT_RES;
        end
        S_WAIT_RES: begin
          if (i_ALU_VALID) begin
            r_res   <= i_ALU_OUT;
            r_flg   <= {{(DATA_WIDTH-4){1'b0}}, i_ALU_CF, i_ALU_OF, i_ALU_EF, i_ALU_ZF};
            r_state <= S_SEND_LO;
          end else if (r_wait == WAIT_LAST) r_state <= S_SEND_ERR;
          else r_wait <= r_wait + WW'(1);
        end
        S_SEND_LO:  if (i_TX_READY) r_state <= S_SEND_HI;
        S_SEND_HI:  if (i_TX_READY) r_state <= S_SEND_FLG;
        S_SEND_FLG: if (i_TX_READY) r_state <= S_IDLE;
        S_SEND_ERR: if (i_TX_READY) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_TX_DATA = '0;
    case (r_state)
      S_SEND_LO:  o_TX_DATA = r_res[DATA_WIDTH-1:0];
      S_SEND_HI:  o_TX_DATA = r_res[2*DATA_WIDTH-1:DATA_WIDTH];
      S_SEND_FLG: o_TX_DATA = r_flg;
      S_SEND_ERR: o_TX_DATA = ERR_BYTE;
      default:    o_TX_DATA = '0;
    endcase
  end

  assign o_TX_VALID  = (r_state == S_SEND_LO) || (r_state == S_SEND_HI) ||
                       (r_state == S_SEND_FLG) || (r_state == S_SEND_ERR);
  assign o_ALU_EN    = (r_state == S_EXEC);
  assign o_ALU_FUN   = r_fun;
  assign o_ALU_A     = r_a;
  assign o_ALU_B     = r_b;
  assign o_BUSY      = w_busy;
  assign o_OVERRUN   = r_overrun;
  assign o_FRAME_ERR = w_gap_to;

endmodule
